// File: rtl/echo_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : echo_fifo
//  Description : Buffered UART echo loop. Words received from a UART receiver
//                (strobe + data) are queued in a FIFO and re-issued to a UART
//                transmitter. Optional case folding, optional CR -> CR-LF
//                expansion, and line-break forwarding.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DW         data word width (case folding needs DW >= 7, acts on [6:0])
//    LGFLEN     log2 of FIFO depth
//    CW         width of the saturating dropped-word counter
//  Ports
//    i_clk      system clock, rising edge
//    i_reset_n  asynchronous active-low reset
//    i_mode     00 raw, 01 upper, 10 lower, 11 swap case (sampled at pop)
//    i_rx_stb   one-cycle strobe qualifying i_rx_data
//    i_rx_data  received word
//    i_rx_break receiver sees line break
//    i_tx_busy  transmitter busy; transfer = o_tx_stb & !i_tx_busy
//    o_tx_stb   word request to transmitter
//    o_tx_data  word to transmit, stable until transferred
//    o_tx_break drive break on TX line
//    o_fill     FIFO occupancy, 0 .. 2**LGFLEN
//    o_overflow sticky, a word was dropped on a full FIFO
//    o_drops    saturating count of dropped words
//    i_clr_ovf  synchronous clear of o_overflow and o_drops
//  Configuration
//    ECHO_CRLF_EN  when defined, every transmitted 0x0D is followed by an
//                  inserted 0x0A that does not occupy a FIFO entry.
// ============================================================================
module echo_fifo #(
    parameter int DW     = 8,
    parameter int LGFLEN = 4,
    parameter int CW     = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [1:0]        i_mode,
    input  logic              i_rx_stb,
    input  logic [DW-1:0]     i_rx_data,
    input  logic              i_rx_break,
    input  logic              i_tx_busy,
    output logic              o_tx_stb,
    output logic [DW-1:0]     o_tx_data,
    output logic              o_tx_break,
    output logic [LGFLEN:0]   o_fill,
    output logic              o_overflow,
    output logic [CW-1:0]     o_drops,
    input  logic              i_clr_ovf
);

    localparam int              c_DEPTH    = 1 << LGFLEN;
    localparam logic [LGFLEN:0] c_FULL     = {1'b1, {LGFLEN{1'b0}}};
    localparam logic [CW-1:0]   c_DROP_MAX = '1;
`ifdef ECHO_CRLF_EN
    localparam logic [DW-1:0]   c_CR       = DW'(8'h0D);
    localparam logic [DW-1:0]   c_LF       = DW'(8'h0A);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_BRK  = 2'd2
`ifdef ECHO_CRLF_EN
        ,
        S_LF   = 2'd3
`endif
    } state_t;

    // ------------------------------------------------------------------
    // Storage and registered state
    // ------------------------------------------------------------------
    logic [DW-1:0]     r_mem [c_DEPTH];
    logic [LGFLEN-1:0] r_wr_ptr;
    logic [LGFLEN-1:0] r_rd_ptr;
    logic [LGFLEN:0]   r_fill;
    logic              r_avail;
    state_t            r_state;
    logic              r_tx_stb;
    logic [DW-1:0]     r_tx_data;
    logic              r_tx_break;
    logic              r_overflow;
    logic [CW-1:0]     r_drops;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t            w_state_nxt;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_full;
    logic              w_empty;
    logic              w_xfer;
    logic              w_rx_ok;
    logic              w_stb_nxt;
    logic [DW-1:0]     w_data_nxt;
    logic              w_brk_nxt;
    logic [DW-1:0]     w_head;
    logic [DW-1:0]     w_head_fold;

    assign w_full  = (r_fill == c_FULL);
    assign w_empty = (r_fill == '0);
    assign w_xfer  = r_tx_stb & ~i_tx_busy;
    assign w_head  = r_mem[r_rd_ptr];

    // A strobe counts as a candidate word only outside break handling.
    assign w_rx_ok = i_rx_stb & ~i_rx_break & (r_state != S_BRK);
    assign w_push  = w_rx_ok & (~w_full | w_pop);
    assign w_drop  = w_rx_ok & w_full & ~w_pop;

    // ------------------------------------------------------------------
    // Case folding of the FIFO head
    // ------------------------------------------------------------------
    generate
        if (DW >= 7) begin : g_fold
            logic [6:0] w_lo;
            logic       w_is_upper;
            logic       w_is_lower;
            logic       w_flip;

            assign w_lo       = w_head[6:0];
            assign w_is_upper = (w_lo >= 7'h41) && (w_lo <= 7'h5A);
            assign w_is_lower = (w_lo >= 7'h61) && (w_lo <= 7'h7A);
            assign w_flip     = ((i_mode == 2'b01) && w_is_lower) ||
                                ((i_mode == 2'b10) && w_is_upper) ||
                                ((i_mode == 2'b11) && (w_is_upper || w_is_lower));
            // Letters differ from their other case only in bit 5.
            assign w_head_fold = w_flip ? (w_head ^ DW'(7'h20)) : w_head;
        end else begin : g_no_fold
            assign w_head_fold = w_head;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM next-state and output-register logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_stb_nxt   = r_tx_stb;
        w_data_nxt  = r_tx_data;
        w_brk_nxt   = r_tx_break;

        case (r_state)
            S_IDLE: begin
                // r_avail lags the count by one cycle, so a fresh word is
                // never popped on the cycle right after its push.
                if (r_avail && !w_empty) begin
                    w_pop       = 1'b1;
                    w_data_nxt  = w_head_fold;
                    w_stb_nxt   = 1'b1;
                    w_state_nxt = S_SEND;
                end else if (w_empty && i_rx_break) begin
                    w_brk_nxt   = 1'b1;
                    w_state_nxt = S_BRK;
                end
            end

            S_SEND: begin
                if (w_xfer) begin
`ifdef ECHO_CRLF_EN
                    if (r_tx_data == c_CR) begin
                        w_data_nxt  = c_LF;
                        w_state_nxt = S_LF;
                    end else
`endif
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_data_nxt = w_head_fold;
                    end else begin
                        w_stb_nxt   = 1'b0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end

`ifdef ECHO_CRLF_EN
            S_LF: begin
                if (w_xfer) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_data_nxt  = w_head_fold;
                        w_state_nxt = S_SEND;
                    end else begin
                        w_stb_nxt   = 1'b0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
`endif

            S_BRK: begin
                if (!i_rx_break) begin
                    w_brk_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_tx_stb   <= 1'b0;
            r_tx_data  <= '0;
            r_tx_break <= 1'b0;
            r_avail    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_stb   <= w_stb_nxt;
            r_tx_data  <= w_data_nxt;
            r_tx_break <= w_brk_nxt;
            r_avail    <= !w_empty;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LGFLEN'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LGFLEN'(1);
            end
            if (w_push && !w_pop) begin
                r_fill <= r_fill + (LGFLEN+1)'(1);
            end else if (!w_push && w_pop) begin
                r_fill <= r_fill - (LGFLEN+1)'(1);
            end
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_rx_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_overflow <= 1'b0;
            r_drops    <= '0;
        end else if (i_clr_ovf) begin
            r_overflow <= 1'b0;
            r_drops    <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drops != c_DROP_MAX) begin
                r_drops <= r_drops + CW'(1);
            end
        end
    end

    assign o_tx_stb   = r_tx_stb;
    assign o_tx_data  = r_tx_data;
    assign o_tx_break = r_tx_break;
    assign o_fill     = r_fill;
    assign o_overflow = r_overflow;
    assign o_drops    = r_drops;

endmodule
`default_nettype wire

// File: tb/tb_echo_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_echo_fifo
//  Description : Scoreboard bench for echo_fifo. Stimulus pushes the expected
//                transmitted words into a queue; a negedge monitor pops and
//                compares on every transfer and checks stall stability.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_echo_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic        rx_stb;
    logic [7:0]  rx_data;
    logic        rx_break;
    logic        tx_busy;
    logic        clr_ovf;
    logic        tx_stb;
    logic [7:0]  tx_data;
    logic        tx_break;
    logic [4:0]  fill;
    logic        overflow;
    logic [15:0] drops;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q[$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data  = 8'h00;
    logic [7:0]  exp_word;

    always #5 clk = ~clk;

    echo_fifo #(.DW(8), .LGFLEN(4), .CW(16)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_mode     (mode),
        .i_rx_stb   (rx_stb),
        .i_rx_data  (rx_data),
        .i_rx_break (rx_break),
        .i_tx_busy  (tx_busy),
        .o_tx_stb   (tx_stb),
        .o_tx_data  (tx_data),
        .o_tx_break (tx_break),
        .o_fill     (fill),
        .o_overflow (overflow),
        .o_drops    (drops),
        .i_clr_ovf  (clr_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs only change 1 time unit after a rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] d);
        rx_stb  = 1'b1;
        rx_data = d;
        step(1);
        rx_stb  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_stb || fill != 0) && n < 400) begin
            step(1);
            n++;
        end
        check({name, "_drain_in_time"}, 32'(n < 400), 32'd1);
        check({name, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    // Monitor: on the negedge the inputs are settled for the coming edge, so
    // stb & !busy here means that edge performs a transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_stb_held", 32'(tx_stb), 32'd1);
                check("stall_data_held", 32'(tx_data), 32'(prev_data));
            end
            if (tx_stb && !tx_busy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got 0x%0h, expected none", tx_data);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("tx_word", 32'(tx_data), 32'(exp_word));
                end
            end
            prev_stall = tx_stb && tx_busy;
            prev_data  = tx_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n    = 1'b0;
        mode     = 2'b00;
        rx_stb   = 1'b0;
        rx_data  = 8'h00;
        rx_break = 1'b0;
        tx_busy  = 1'b0;
        clr_ovf  = 1'b0;

        // ---------------- T1: reset state and latency ----------------
        step(3);
        check("rst_tx_stb",   32'(tx_stb),   32'd0);
        check("rst_tx_data",  32'(tx_data),  32'd0);
        check("rst_tx_break", 32'(tx_break), 32'd0);
        check("rst_fill",     32'(fill),     32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drops",    32'(drops),    32'd0);
        rst_n = 1'b1;
        step(2);

        exp_q.push_back(8'h41);
        push(8'h41);                               // sampled at edge N
        check("lat_fill_N",  32'(fill),   32'd1);
        check("lat_stb_N",   32'(tx_stb), 32'd0);
        step(1);
        check("lat_stb_N1",  32'(tx_stb), 32'd0);
        step(1);
        check("lat_stb_N2",  32'(tx_stb), 32'd1);
        check("lat_data_N2", 32'(tx_data), 32'h41);
        drain("t1");

        // ---------------- T2: case folding ----------------
        mode = 2'b01;
        exp_q.push_back(8'h41); exp_q.push_back(8'h5A); exp_q.push_back(8'h39);
        push(8'h61); push(8'h5A); push(8'h39);
        drain("t2_upper");
        mode = 2'b11;
        exp_q.push_back(8'h41); exp_q.push_back(8'h7A); exp_q.push_back(8'h39);
        push(8'h61); push(8'h5A); push(8'h39);
        drain("t2_swap");
        mode = 2'b10;
        exp_q.push_back(8'h61); exp_q.push_back(8'h62); exp_q.push_back(8'h40);
        push(8'h41); push(8'h62); push(8'h40);
        drain("t2_lower");
        mode = 2'b00;

        // ---------------- T3: overflow ----------------
        // Occupy the output register first so the 20 pushes all land in
        // the FIFO: 16 stored, 4 dropped.
        tx_busy = 1'b1;
        exp_q.push_back(8'hFF);
        push(8'hFF);
        step(4);
        check("t3_head_waiting", 32'(tx_stb), 32'd1);
        for (int i = 0; i < 20; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            push(8'(i));
        end
        check("t3_fill",     32'(fill),     32'd16);
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_drops",    32'(drops),    32'd4);
        tx_busy = 1'b0;
        drain("t3");
        check("t3_overflow_sticky", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        check("t3_clr_overflow", 32'(overflow), 32'd0);
        check("t3_clr_drops",    32'(drops),    32'd0);

        // ---------------- T4: random stalls at full input rate ----------------
        fork
            begin
                for (int i = 0; i < 64; i++) begin
                    exp_q.push_back(8'h80 + 8'(i));
                    push(8'h80 + 8'(i));
                end
            end
            begin
                for (int k = 0; k < 64; k++) begin
                    tx_busy = ($urandom_range(0, 7) == 0);
                    step(1);
                end
            end
        join
        tx_busy = 1'b0;
        drain("t4");
        check("t4_drops",    32'(drops),    32'd0);
        check("t4_overflow", 32'(overflow), 32'd0);
        check("t4_fill",     32'(fill),     32'd0);

        // ---------------- T5: CR handling ----------------
        exp_q.push_back(8'h68);
        exp_q.push_back(8'h0D);
`ifdef ECHO_CRLF_EN
        exp_q.push_back(8'h0A);
`endif
        exp_q.push_back(8'h69);
        push(8'h68); push(8'h0D); push(8'h69);
        drain("t5");

        // ---------------- T6: break forwarding ----------------
        tx_busy = 1'b1;
        exp_q.push_back(8'h31); exp_q.push_back(8'h32); exp_q.push_back(8'h33);
        push(8'h31); push(8'h32); push(8'h33);
        step(3);
        rx_break = 1'b1;
        tx_busy  = 1'b0;
        n = 0;
        while (!tx_break && n < 50) begin
            step(1);
            n++;
        end
        check("t6_break_in_time",  32'(n < 50), 32'd1);
        check("t6_words_first",    exp_q.size(), 32'd0);
        check("t6_tx_break_on",    32'(tx_break), 32'd1);
        push(8'h55);                                // stray strobe, must not enter
        step(2);
        check("t6_stray_fill", 32'(fill),   32'd0);
        check("t6_stray_stb",  32'(tx_stb), 32'd0);
        rx_break = 1'b0;
        step(2);
        check("t6_tx_break_off", 32'(tx_break), 32'd0);
        step(4);

        // Asynchronous reset in the middle of a pending transfer.
        tx_busy = 1'b1;
        exp_q.push_back(8'h77);
        push(8'h77);
        push(8'h78);
        step(4);
        check("t6_pending_stb", 32'(tx_stb), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_stb",  32'(tx_stb),  32'd0);
        check("t6_async_fill", 32'(fill),    32'd0);
        check("t6_async_data", 32'(tx_data), 32'd0);
        exp_q.delete();
        step(2);
        rst_n   = 1'b1;
        tx_busy = 1'b0;
        step(5);
        check("t6_post_reset_stb",  32'(tx_stb), 32'd0);
        check("t6_post_reset_fill", 32'(fill),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
